// File: rtl/fft32_pkg.sv
// Shared constants and types for the 32-point radix-2 DIF SDF FFT pipeline.
package fft32_pkg;

    localparam int unsigned DW      = 11;
    localparam int unsigned TW      = 11;
    localparam int unsigned OW      = DW + 1;
    localparam int unsigned TW_FRAC = 10;
    localparam int unsigned ROUND_K = 512;

    // Feedback delay length of stages 1..5.
    localparam int unsigned STAGE_DELAY [5] = '{16, 8, 4, 2, 1};

    typedef enum logic {
        PhFill = 1'b0,
        PhBfly = 1'b1
    } phase_e;

endpackage

// File: rtl/cmul_round_sat.sv
// Complex multiply by a Q1.10 twiddle, round half up, then saturate to OW bits.
module cmul_round_sat
    import fft32_pkg::*;
#(
    parameter int unsigned XW   = 12,
    parameter int unsigned WW   = 11,
    parameter int unsigned OW   = 12,
    parameter int unsigned FRAC = TW_FRAC,
    parameter int unsigned RND  = ROUND_K
) (
    input  logic signed [XW-1:0] x_re_i,
    input  logic signed [XW-1:0] x_im_i,
    input  logic signed [WW-1:0] w_re_i,
    input  logic signed [WW-1:0] w_im_i,
    output logic signed [OW-1:0] y_re_o,
    output logic signed [OW-1:0] y_im_o
);

    // Two guard bits: one for the sum of products, one for the rounding add.
    localparam int unsigned PW = XW + WW + 2;

    localparam logic signed [PW-1:0] RndK = PW'(RND);
    localparam logic signed [PW-1:0] OMax = {{(PW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [PW-1:0] OMin = ~OMax;

    logic signed [PW-1:0] p_re, p_im;
    logic signed [PW-1:0] r_re, r_im;

    always_comb begin
        p_re = PW'(x_re_i) * PW'(w_re_i) - PW'(x_im_i) * PW'(w_im_i);
        p_im = PW'(x_re_i) * PW'(w_im_i) + PW'(x_im_i) * PW'(w_re_i);
        r_re = (p_re + RndK) >>> FRAC;
        r_im = (p_im + RndK) >>> FRAC;

        if (r_re > OMax) begin
            y_re_o = OMax[OW-1:0];
        end else if (r_re < OMin) begin
            y_re_o = OMin[OW-1:0];
        end else begin
            y_re_o = r_re[OW-1:0];
        end

        if (r_im > OMax) begin
            y_im_o = OMax[OW-1:0];
        end else if (r_im < OMin) begin
            y_im_o = OMin[OW-1:0];
        end else begin
            y_im_o = r_im[OW-1:0];
        end
    end

endmodule

// File: rtl/fft32_sdf_stage4.sv
// Stage 4 of the 32-point SDF FFT: delay-2 feedback butterfly followed by a
// twiddle multiply (W0/W8 from an external ROM) with rounding and saturation.
module fft32_sdf_stage4 #(
    parameter int unsigned DW = fft32_pkg::DW,
    parameter int unsigned TW = fft32_pkg::TW,
    parameter int unsigned OW = DW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data_re,
    input  logic [DW-1:0] i_data_im,
    output logic          o_rom_addr,
    input  logic [TW-1:0] i_rom_re,
    input  logic [TW-1:0] i_rom_im,
    output logic          o_valid,
    output logic [OW-1:0] o_data_re,
    output logic [OW-1:0] o_data_im
);
    import fft32_pkg::*;

    logic [4:0]           cnt_q;
    logic                 primed_q;
    logic signed [OW-1:0] dl_re_q [2];
    logic signed [OW-1:0] dl_im_q [2];
    logic                 valid_q;
    logic [OW-1:0]        data_re_q, data_im_q;

    phase_e               phase;
    logic signed [OW-1:0] in_re, in_im;
    logic signed [OW-1:0] x_re, x_im;
    logic signed [OW-1:0] dl_in_re, dl_in_im;
    logic signed [OW-1:0] y_re, y_im;

    assign phase = phase_e'(cnt_q[1]);
    assign in_re = OW'($signed(i_data_re));
    assign in_im = OW'($signed(i_data_im));

    // In BFLY the address is 0, so the ROM already returns W0.
    assign o_rom_addr = ~cnt_q[1] & cnt_q[0];

    always_comb begin
        x_re     = dl_re_q[1];
        x_im     = dl_im_q[1];
        dl_in_re = in_re;
        dl_in_im = in_im;
        if (phase == PhBfly) begin
            x_re     = dl_re_q[1] + in_re;
            x_im     = dl_im_q[1] + in_im;
            dl_in_re = dl_re_q[1] - in_re;
            dl_in_im = dl_im_q[1] - in_im;
        end
    end

    cmul_round_sat #(
        .XW   (OW),
        .WW   (TW),
        .OW   (OW),
        .FRAC (TW_FRAC),
        .RND  (ROUND_K)
    ) u_cmul (
        .x_re_i (x_re),
        .x_im_i (x_im),
        .w_re_i ($signed(i_rom_re)),
        .w_im_i ($signed(i_rom_im)),
        .y_re_o (y_re),
        .y_im_o (y_im)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q      <= '0;
            primed_q   <= 1'b0;
            dl_re_q[0] <= '0;
            dl_re_q[1] <= '0;
            dl_im_q[0] <= '0;
            dl_im_q[1] <= '0;
            valid_q    <= 1'b0;
            data_re_q  <= '0;
            data_im_q  <= '0;
        end else begin
            // Until the first BFLY the delay line holds no real differences.
            valid_q <= i_valid & (primed_q | cnt_q[1]);
            if (i_valid) begin
                cnt_q      <= cnt_q + 5'd1;
                dl_re_q[0] <= dl_in_re;
                dl_im_q[0] <= dl_in_im;
                dl_re_q[1] <= dl_re_q[0];
                dl_im_q[1] <= dl_im_q[0];
                data_re_q  <= y_re;
                data_im_q  <= y_im;
                if (phase == PhBfly) begin
                    primed_q <= 1'b1;
                end
            end
        end
    end

    assign o_valid   = valid_q;
    assign o_data_re = data_re_q;
    assign o_data_im = data_im_q;

endmodule

// File: tb/tb_fft32_sdf_stage4.sv
// Directed, table-driven bench for fft32_sdf_stage4 with a bench-side twiddle ROM.
module tb_fft32_sdf_stage4;

    logic               clk;
    logic               rst;
    logic               valid;
    logic signed [10:0] data_re, data_im;
    logic               rom_addr;
    logic signed [10:0] rom_re, rom_im;
    logic               o_valid;
    logic signed [11:0] o_re, o_im;

    logic               rom_ovr;
    logic signed [10:0] ovr_re, ovr_im;

    int n_checks = 0;
    int n_fail   = 0;
    int mcnt     = 0;
    int last_re  = 0;
    int last_im  = 0;
    bit have_last = 1'b0;

    typedef struct {
        int re;
        int im;
        bit ev;
        int er;
        int ei;
    } vec_t;

    vec_t tab [14];

    fft32_sdf_stage4 dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (valid),
        .i_data_re  (data_re),
        .i_data_im  (data_im),
        .o_rom_addr (rom_addr),
        .i_rom_re   (rom_re),
        .i_rom_im   (rom_im),
        .o_valid    (o_valid),
        .o_data_re  (o_re),
        .o_data_im  (o_im)
    );

    always #5 clk = ~clk;

    // Stage-4 ROM: W0 = 1023 + j0, W8 = 0 - j1024; override for saturation cases.
    always_comb begin
        rom_re = 11'd1023;
        rom_im = 11'd0;
        if (rom_ovr) begin
            rom_re = ovr_re;
            rom_im = ovr_im;
        end else if (rom_addr) begin
            rom_re = 11'd0;
            rom_im = 11'h400;
        end
    end

    function automatic vec_t mk(int re, int im, bit ev, int er, int ei);
        vec_t v;
        v.re = re;
        v.im = im;
        v.ev = ev;
        v.er = er;
        v.ei = ei;
        return v;
    endfunction

    task automatic chk(string name, int idx, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_cleared(int idx);
        chk("rst_o_valid", idx, int'(o_valid), 0);
        chk("rst_o_re", idx, int'(o_re), 0);
        chk("rst_o_im", idx, int'(o_im), 0);
        chk("rst_rom_addr", idx, int'(rom_addr), 0);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(int idx, bit v, int re, int im, bit ev, int er, int ei);
        valid   = v;
        data_re = 11'(re);
        data_im = 11'(im);
        #1;
        chk("rom_addr", idx, int'(rom_addr), ((mcnt & 3) == 1) ? 1 : 0);
        @(posedge clk);
        #1;
        chk("o_valid", idx, int'(o_valid), int'(ev));
        if (v && ev) begin
            chk("o_re", idx, int'(o_re), er);
            chk("o_im", idx, int'(o_im), ei);
            last_re   = er;
            last_im   = ei;
            have_last = 1'b1;
        end else if (v) begin
            have_last = 1'b0;
        end else if (have_last) begin
            chk("hold_re", idx, int'(o_re), last_re);
            chk("hold_im", idx, int'(o_im), last_im);
        end
        if (v) mcnt = (mcnt + 1) % 32;
        @(negedge clk);
    endtask

    task automatic reset_pulse(int idx);
        rst = 1'b1;
        #1;
        check_cleared(idx);
        @(negedge clk);
        rst       = 1'b0;
        mcnt      = 0;
        last_re   = 0;
        last_im   = 0;
        have_last = 1'b1;
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        valid   = 1'b0;
        data_re = '0;
        data_im = '0;
        rom_ovr = 1'b0;
        ovr_re  = '0;
        ovr_im  = '0;

        tab[0]  = mk(100, 0, 0, 0, 0);
        tab[1]  = mk(7, 0, 0, 0, 0);
        tab[2]  = mk(50, 0, 1, 150, 0);
        tab[3]  = mk(3, 0, 1, 10, 0);
        tab[4]  = mk(-1024, 0, 1, 50, 0);
        tab[5]  = mk(0, 20, 1, 0, -4);
        tab[6]  = mk(-1024, 0, 1, -2046, 0);
        tab[7]  = mk(0, -20, 1, 0, 0);
        tab[8]  = mk(0, 5, 1, 0, 0);
        tab[9]  = mk(-1024, 0, 1, 40, 0);
        tab[10] = mk(3, 0, 1, 3, 5);
        tab[11] = mk(1023, 0, 1, -1, 0);
        tab[12] = mk(0, 0, 1, -3, 5);
        tab[13] = mk(0, 0, 1, 0, 2047);

        // Reset hold, release, idle, then an idle reset pulse.
        repeat (3) begin
            @(negedge clk);
            check_cleared(0);
        end
        rst       = 1'b0;
        have_last = 1'b1;
        step(100, 0, 0, 0, 0, 0, 0);
        step(101, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check_cleared(1);
        #1;
        rst = 1'b0;
        #1;
        check_cleared(2);
        @(negedge clk);
        step(102, 0, 0, 0, 0, 0, 0);

        // Gapped valid 1,0,0,1,...: same outputs, each one cycle after its input.
        for (int i = 0; i < 14; i++) begin
            step(i, 1, tab[i].re, tab[i].im, tab[i].ev, tab[i].er, tab[i].ei);
            step(200 + i, 0, 0, 0, 0, 0, 0);
            step(300 + i, 0, 0, 0, 0, 0, 0);
        end
        reset_pulse(3);

        // Continuous run, then async reset mid-frame at cnt = 13.
        for (int i = 0; i < 13; i++) begin
            step(400 + i, 1, tab[i].re, tab[i].im, tab[i].ev, tab[i].er, tab[i].ei);
        end
        reset_pulse(4);

        // Fresh frame after mid-frame reset: fill suppressed, then reference output.
        for (int i = 0; i < 14; i++) begin
            step(500 + i, 1, tab[i].re, tab[i].im, tab[i].ev, tab[i].er, tab[i].ei);
        end
        step(520, 0, 0, 0, 0, 0, 0);
        reset_pulse(5);

        // Saturation with an overridden twiddle of -1024 - j1024.
        step(600, 1, -1024, 0, 0, 0, 0);
        step(601, 1, 1023, -1024, 0, 0, 0);
        rom_ovr = 1'b1;
        ovr_re  = 11'h400;
        ovr_im  = 11'h400;
        step(602, 1, -1024, 0, 1, 2047, 2047);
        step(603, 1, 1023, -1024, 1, -2048, 2);
        rom_ovr = 1'b0;
        step(604, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft32_sdf_stage4.md
Name: fft32_sdf_stage4

Overview:
- Stage 4 of the 32-point radix-2 DIF single-path delay-feedback (SDF) FFT pipeline.
- Reads the stage-4 twiddle ROM, which returns W0 = 1023 + j0 and W8 = 0 − j1024 in Q1.10. The block drives the ROM address and consumes its combinational output.
- Function: a delay-2 feedback butterfly plus a complex twiddle multiply, with rounding and saturation.
- Sits between fft32_sdf_stage3 (input) and fft32_sdf_stage5 (output).

Parameters:
- DW, 11, input data width per real/imag component (two's complement, Q1.10).
- TW, 11, twiddle word width (matches the ROM word length).
- OW, DW+1, output width per component; carries the butterfly's one bit of growth.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  input sample strobe; the whole stage advances only when this is 1.
- i_data_re  input  DW  input sample, real part.
- i_data_im  input  DW  input sample, imaginary part.
- o_rom_addr  output  1  twiddle ROM address: 0 selects W0, 1 selects W8.
- i_rom_re  input  TW  ROM output, real part (combinational from o_rom_addr).
- i_rom_im  input  TW  ROM output, imaginary part.
- o_valid  output  1  output sample strobe.
- o_data_re  output  OW  output sample, real part (registered).
- o_data_im  output  OW  output sample, imaginary part (registered).

Behaviour:
- Reset: async assert clears cnt (5 bit), both delay-line entries (2 × complex OW), primed flag, o_valid, o_data_re and o_data_im. Reset mid-frame discards all state; the next i_valid sample is frame index 0.
- cnt increments on each i_valid and wraps 31→0. No advance, write or output while i_valid = 0; all registers hold.
- Phase select is cnt[1].
- FILL (cnt[1] = 0):
  - Delay line shifts in the sign-extended input.
  - Datapath operand X = delay-line head (a difference from the previous butterfly).
  - Twiddle index k = cnt[0].
- BFLY (cnt[1] = 1):
  - a = delay-line head, b = input.
  - X = a + b; the twiddle is forced to W0.
  - a − b shifts into the delay line.
- o_rom_addr (combinational) = ~cnt[1] & cnt[0].
- Multiply:
  - P = X · (i_rom_re + j·i_rom_im), full-precision complex product.
  - Each component = (P + 512) >>> 10 (round half up, arithmetic shift).
  - Then saturate to [−2^(OW−1), 2^(OW−1)−1].
- Latency: the output is registered on the same edge as the accepted input, so o_valid and o_data appear one cycle after the i_valid that produced them.
- primed flag:
  - Set on the first BFLY-phase sample after reset.
  - o_valid = i_valid (registered) & (primed | cnt[1]).
  - Effect: the first two FILL outputs after reset (garbage delay line) are suppressed.
- Frame boundary: the last two differences of a frame leave during the first FILL phase (cnt 0,1) of the next frame. There is no flush; the upstream streams continuously.
- When i_valid = 0, o_valid drops to 0 the next cycle and o_data holds its last value.
- Output order per group of 4: sum0, sum1 (during BFLY), then diff0·W0, diff1·W8 (emitted in the next FILL).

Decomposition:
- Shared package fft32_pkg holds:
  - DW, TW, OW;
  - twiddle fractional bits (10) and rounding constant (512);
  - stage delay lengths (16, 8, 4, 2, 1).
- Natural sub-module: cmul_round_sat, the complex multiply with rounding and saturation, reused by stages 1–4.
- Delay line, counter and butterfly remain inline.

Test Plan:
- Reset hold, then i_rst pulse while idle → o_valid = 0 and o_data = 0 throughout; o_rom_addr = 0.
- Samples 100, 7, 50, 3 (real) with continuous valid, then 0, 0:
  - outputs after prime: 150, 10;
  - then re = 50 → (50·1023 + 512) >>> 10 = 50;
  - then W8 applied to 4 → re = 0, im = −4;
  - o_rom_addr toggles 0, 1 in FILL.
- Complex diff: a = 0 + j20, b = 0 − j20 at k = 1 → diff = j40, times −j → output re = 40, im = 0.
- Extremes: a = −1024, b = 1023 at k = 1 → diff re = −2047 → output im = 2047, no wrap. Sum of −1024 and −1024 → −2048 → rounded to −2046.
- Gapped valid (1,0,0,1,…) → output sequence identical to the continuous run, with o_valid only one cycle after each input valid.
- Async i_rst mid-frame at cnt = 13 → all outputs cleared immediately. The next two FILL outputs are suppressed; the following frame matches the reference model from index 0.
